// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Bundles the button pins and the conditioned outputs of button_conditioner.
//   master : board / game-control side (drives btn_n, consumes results)
//   slave  : button_conditioner itself
//   Signals:
//     btn_n         raw active-low button pins, asynchronous to clk
//     btn_level     debounced level, 1 = pressed
//     press_pulse   one-cycle pulse on a 0->1 change of btn_level
//     release_pulse one-cycle pulse on a 1->0 change of btn_level
//     press_count   population count of press_pulse in the same cycle
//     ready         every channel has completed its initial debounce
interface button_conditioner_if #(
    parameter int N_BTN = 5
);
    localparam int PC_W = $clog2(N_BTN + 1);

    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [PC_W-1:0]  press_count;
    logic             ready;

    modport master (
        output btn_n,
        input  btn_level, press_pulse, release_pulse, press_count, ready
    );

    modport slave (
        input  btn_n,
        output btn_level, press_pulse, release_pulse, press_count, ready
    );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronises, debounces and edge-detects N_BTN active-low buttons.
//   Ports:
//     clk    single clock, rising edge
//     reset  synchronous, active-high
//     bus    button_conditioner_if.slave (btn_n in; btn_level, press_pulse,
//            release_pulse, press_count, ready out)
//   A level change is accepted after DEBOUNCE_CYCLES consecutive differing
//   samples; pulses and press_count are registered alongside btn_level.
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    button_conditioner_if.slave   bus
);
    localparam int              PC_W = $clog2(N_BTN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        INIT   = 1'b0,
        STABLE = 1'b1
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [1:0]       r_vld;
    state_t           r_state [N_BTN];
    logic [CNT_W-1:0] r_cnt   [N_BTN];
    logic [N_BTN-1:0] r_prev;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic [PC_W-1:0]  r_press_count;
    logic             r_ready;

    logic [N_BTN-1:0] w_s;
    state_t           w_state_nxt [N_BTN];
    logic [CNT_W-1:0] w_cnt_nxt   [N_BTN];
    logic [N_BTN-1:0] w_prev_nxt;
    logic [N_BTN-1:0] w_level_nxt;
    logic [N_BTN-1:0] w_press_nxt;
    logic [N_BTN-1:0] w_release_nxt;
    logic [PC_W-1:0]  w_press_count_nxt;
    logic             w_all_stable;

    assign w_s = ~r_sync2;

    // r_vld tracks how far the synchroniser has filled since reset. The
    // channel FSMs only compare once r_vld[1] is set, so the first comparison
    // after reset lands on the third edge, same as for a raw input edge.
    always_comb begin
        w_prev_nxt        = r_prev;
        w_level_nxt       = r_level;
        w_press_nxt       = '0;
        w_release_nxt     = '0;
        w_press_count_nxt = '0;
        w_all_stable      = 1'b1;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            if (r_state[i] != STABLE) begin
                w_all_stable = 1'b0;
            end
            if (r_vld[1]) begin
                case (r_state[i])
                    INIT: begin
                        if (w_s[i] == r_prev[i]) begin
                            if (r_cnt[i] == LAST) begin
                                // Initial level is adopted silently: no pulse.
                                w_level_nxt[i] = w_s[i];
                                w_cnt_nxt[i]   = '0;
                                w_state_nxt[i] = STABLE;
                            end else begin
                                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                            end
                        end else begin
                            w_cnt_nxt[i]  = '0;
                            w_prev_nxt[i] = w_s[i];
                        end
                    end
                    STABLE: begin
                        if (w_s[i] == r_level[i]) begin
                            w_cnt_nxt[i] = '0;
                        end else if (r_cnt[i] == LAST) begin
                            w_level_nxt[i]   = w_s[i];
                            w_cnt_nxt[i]     = '0;
                            w_press_nxt[i]   = w_s[i];
                            w_release_nxt[i] = ~w_s[i];
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                        end
                    end
                    default: w_state_nxt[i] = INIT;
                endcase
            end
        end
        for (int unsigned i = 0; i < N_BTN; i++) begin
            w_press_count_nxt = w_press_count_nxt + PC_W'(w_press_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1       <= '1;
            r_sync2       <= '1;
            r_vld         <= '0;
            r_prev        <= '0;
            r_level       <= '0;
            r_press       <= '0;
            r_release     <= '0;
            r_press_count <= '0;
            r_ready       <= 1'b0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                r_state[i] <= INIT;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1       <= bus.btn_n;
            r_sync2       <= r_sync1;
            r_vld         <= {r_vld[0], 1'b1};
            r_prev        <= w_prev_nxt;
            r_level       <= w_level_nxt;
            r_press       <= w_press_nxt;
            r_release     <= w_release_nxt;
            r_press_count <= w_press_count_nxt;
            r_ready       <= r_ready | w_all_stable;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    assign bus.btn_level     = r_level;
    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.press_count   = r_press_count;
    assign bus.ready         = r_ready;
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Synchronises, debounces and edge-detects the five active-low arcade buttons before they reach the game-control logic in `main`. Each raw pin becomes three outputs: a clean pressed level, a single-cycle press pulse and a single-cycle release pulse. The block also reports how many presses occurred in the same cycle, so the score accumulator can add that count directly instead of comparing against previous-sample registers. It runs on the 25 MHz processor clock `clk25`, fed in as `clk`.

## Interface

Parameters:
- `N_BTN`, default 5: number of button channels.
- `DEBOUNCE_CYCLES`, default 250000 (10 ms at 25 MHz): consecutive stable samples required to accept a level. Legal range is 2 to 2^`CNT_W`−1.
- `CNT_W`, default 18: width of each per-channel debounce counter.

Ports:
- `clk`, input, 1 bit: the single clock (`clk25` at top level). All logic is on its rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `btn_n`, input, `N_BTN` bits: raw button pins, 0 = pressed. Asynchronous to `clk`.
- `btn_level`, output, `N_BTN` bits: debounced level, 1 = pressed.
- `press_pulse`, output, `N_BTN` bits: one-cycle high when a channel's `btn_level` goes 0→1.
- `release_pulse`, output, `N_BTN` bits: one-cycle high when a channel's `btn_level` goes 1→0.
- `press_count`, output, `$clog2(N_BTN+1)` bits (3 bits at default): population count of `press_pulse` in the same cycle.
- `ready`, output, 1 bit: high once every channel has left INIT.

## Operation

- **Synchroniser.** Each channel has a two-flop synchroniser. Both flops reset to 1 (released). The second flop's output, inverted, is that channel's sample `s` (1 = pressed).
- **Per-channel state machine.** Two states, INIT and STABLE. Each channel also holds a counter `cnt` (`CNT_W` bits), a reference `prev`, and the output `level`.
- **Reset.**
  - Enter INIT, with `cnt` = 0, `prev` = 0, `level` = 0.
  - All pulses = 0, `press_count` = 0, `ready` = 0.
- **INIT.**
  - Each cycle: if `s` == `prev`, `cnt` increments; otherwise `cnt` = 0 and `prev` = `s`.
  - When `s` == `prev` and `cnt` == `DEBOUNCE_CYCLES`−1: load `level` = `s`, set `cnt` = 0, go to STABLE.
  - No pulse is ever generated on leaving INIT. A button held through reset is therefore never reported as a press.
- **STABLE.**
  - If `s` == `level`: `cnt` = 0.
  - If `s` != `level` and `cnt` < `DEBOUNCE_CYCLES`−1: `cnt` increments.
  - If `s` != `level` and `cnt` == `DEBOUNCE_CYCLES`−1: `level` toggles, `cnt` = 0, and the matching pulse is asserted.
  - Net effect: a change needs exactly `DEBOUNCE_CYCLES` consecutive differing samples. Any glitch shorter than that restarts the count.
- **Outputs.**
  - `press_pulse`, `release_pulse` and `press_count` are registered. They are asserted in the same cycle that `btn_level` shows the new value, and last exactly one cycle.
  - `press_count` counts 0 to `N_BTN` with no overflow. With 5 simultaneous presses it is 5.
  - `ready` = AND over all channels of (state == STABLE). It is registered and stays 1 until the next reset.
- **Independence.** Channels never interact. Simultaneous events on different channels all appear in the same cycle.
- **Counter saturation.** `cnt` never exceeds `DEBOUNCE_CYCLES`−1, so it never wraps.

## Timing

- **Input latency.** Raw edge captured by sync flop 1 at edge E1, reaches `s` after edge E2. Comparisons happen at E3 through E(`DEBOUNCE_CYCLES`+2). `btn_level` and the pulse update at edge E(`DEBOUNCE_CYCLES`+2).
- **`ready` after reset.** Reset deasserts before edge R1. With buttons steady, every channel leaves INIT at edge R(`DEBOUNCE_CYCLES`+2), and `ready` rises one edge later.
- **Reset mid-debounce.** Clears all counters and pulses on the same edge. A pulse due on that edge is dropped.
- **Reset versus pulse.** Reset takes priority over any pulse generation.
- **Throughput.** The same channel can produce a press and its following release no closer than `DEBOUNCE_CYCLES` cycles apart.

## Test plan

All directed tests use `DEBOUNCE_CYCLES` = 4.

- **Power-up, all released.** `btn_n` = 5'b11111 through and after reset. `btn_level` = 0, no pulses, `ready` = 1 on edge R7.
- **Clean press and release.** Drive `btn_n[2]` = 0 for 20 cycles, then 1.
  - `btn_level[2]` rises at E6, with `press_pulse` = 5'b00100 for one cycle and `press_count` = 1.
  - The release produces `release_pulse[2]` one cycle, 6 edges after the release is captured.
- **Bounce.** Drive `btn_n[0]` with the pattern 0,1,0,0,1,0,0,0,0 (one value per cycle). Exactly one `press_pulse[0]`, on the edge that completes the final four-sample run.
- **Simultaneous presses.** Drop all five `btn_n` bits on the same cycle. `press_pulse` = 5'b11111 and `press_count` = 5 in the same single cycle.
- **Held through reset.** Hold `btn_n[1]` = 0 during and after reset. `btn_level[1]` goes to 1 with no `press_pulse[1]`. A later release gives `release_pulse[1]`.
- **Reset mid-debounce.** Start a press on channel 3, then assert reset 2 cycles before the flip. No pulse is generated, all counters are 0, and INIT restarts.
